version_slot_controller: RTL and testbench

//  Owns the VERSION_NUM data slots plus their version tags, which feed the multi-version read router.

---
 rtl/version_slot_controller.sv | 123 ++++++++++++
 tb/tb_version_slot_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/version_slot_controller.sv
// version_slot_controller: versioned data slots with round-robin replacement, version-wrap flush and newest-<=-version reads; optional pin support under VSC_PIN_EN
module version_slot_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic                               wrValid,
  output logic                               wrReady,
  input  logic [DATA_WIDTH-1:0]              wrData,
  output logic [VERSION_WIDTH-1:0]           wrVersion,
  input  logic                               rdValid,
  output logic                               rdReady,
  input  logic [VERSION_WIDTH-1:0]           rdVersion,
  output logic                               respValid,
  output logic                               respHit,
  output logic [DATA_WIDTH-1:0]              respData,
  output logic [VERSION_WIDTH-1:0]           respVersion,
  output logic [$clog2(VERSION_NUM+1)-1:0]   validCount
`ifdef VSC_PIN_EN
  ,
  input  logic                               pinValid,
  input  logic [VERSION_WIDTH-1:0]           pinVersion
`endif
);
  localparam int PW = $clog2(VERSION_NUM);
  localparam int CW = $clog2(VERSION_NUM + 1);
  localparam logic [VERSION_WIDTH-1:0] MAX_VER = '1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [VERSION_WIDTH-1:0] tags [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    data [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] next_ver;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            wr_slot;
  logic [PW-1:0]            sel;
  logic [VERSION_WIDTH-1:0] sel_tag;
  logic                     wr_acc;
  logic                     rd_acc;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(VERSION_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_acc    = wrValid & wrReady;
  assign rd_acc    = rdValid & rdReady;
  assign wrVersion = next_ver;
`ifdef VSC_PIN_EN
  assign wr_slot = (pinValid && tags[wr_ptr] == pinVersion) ? inc(wr_ptr) : wr_ptr;
`else
  assign wr_slot = wr_ptr;
`endif

  // pick the slot holding the largest nonzero tag not above the requested version
  always_comb begin
    sel     = '0;
    sel_tag = '0;
    for (int i = 0; i < VERSION_NUM; i++)
      if (tags[i] <= rdVersion && tags[i] > sel_tag) begin
        sel     = PW'(i);
        sel_tag = tags[i];
      end
  end

  // control FSM: tag allocation, replacement pointer, occupancy and the one-cycle wrap flush
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= RUN;
      wrReady    <= 1'b0;
      rdReady    <= 1'b0;
      next_ver   <= VERSION_WIDTH'(1);
      wr_ptr     <= '0;
      validCount <= '0;
      for (int i = 0; i < VERSION_NUM; i++) tags[i] <= '0;
    end else if (state == FLUSH) begin
      state      <= RUN;
      wrReady    <= 1'b1;
      rdReady    <= 1'b1;
      next_ver   <= VERSION_WIDTH'(1);
      wr_ptr     <= '0;
      validCount <= '0;
      for (int i = 0; i < VERSION_NUM; i++) tags[i] <= '0;
    end else begin
      wrReady <= 1'b1;
      rdReady <= 1'b1;
      if (wr_acc) begin
        tags[wr_slot] <= next_ver;
        next_ver      <= next_ver + 1'b1;
        wr_ptr        <= inc(wr_slot);
        if (tags[wr_slot] == '0 && validCount != CW'(VERSION_NUM)) validCount <= validCount + 1'b1;
        if (next_ver == MAX_VER) begin
          state   <= FLUSH;
          wrReady <= 1'b0;
          rdReady <= 1'b0;
        end
      end
    end
  end

  // slot payload storage
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) for (int i = 0; i < VERSION_NUM; i++) data[i] <= '0;
    else if (wr_acc) data[wr_slot] <= wrData;
  end

  // registered read response from pre-write slot contents
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      respValid   <= 1'b0;
      respHit     <= 1'b0;
      respData    <= '0;
      respVersion <= '0;
    end else begin
      respValid <= rd_acc;
      if (rd_acc) begin
        respHit     <= sel_tag != '0;
        respData    <= (sel_tag != '0) ? data[sel] : '0;
        respVersion <= sel_tag;
      end
    end
  end
endmodule

// File: tb/tb_version_slot_controller.sv
// tb_version_slot_controller: directed stimulus against a queue-based model of live versions plus literal expectations
module tb_version_slot_controller;
  localparam int DW = 32;
  localparam int VW = 4;
  localparam int N  = 4;
  logic clk = 0, rstN = 0, wrValid = 0, rdValid = 0;
  logic [DW-1:0] wrData = '0;
  logic [VW-1:0] rdVersion = '0;
  logic wrReady, rdReady, respValid, respHit;
  logic [VW-1:0] wrVersion, respVersion;
  logic [DW-1:0] respData;
  logic [$clog2(N+1)-1:0] validCount;
`ifdef VSC_PIN_EN
  logic pinValid = 0;
  logic [VW-1:0] pinVersion = '0;
`endif
  int checks = 0, failures = 0;

  version_slot_controller #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(N)) dut (
    .clk(clk), .rstN(rstN), .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
    .wrVersion(wrVersion), .rdValid(rdValid), .rdReady(rdReady), .rdVersion(rdVersion),
    .respValid(respValid), .respHit(respHit), .respData(respData), .respVersion(respVersion),
    .validCount(validCount)
`ifdef VSC_PIN_EN
    , .pinValid(pinValid), .pinVersion(pinVersion)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: the live set is the most recent N versions since the last flush (pinned one kept)
  typedef struct {int ver; logic [DW-1:0] d;} ent_t;
  ent_t live[$];
  int nv = 1, m_ver = 0;
  bit m_ready = 0, m_flush = 0, m_rv = 0, m_hit = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      live.delete(); nv = 1; m_ready = 0; m_flush = 0; m_rv = 0; m_hit = 0; m_data = '0; m_ver = 0;
    end else begin
      m_rv = rdValid && m_ready;
      if (m_rv) begin
        m_hit = 0; m_data = '0; m_ver = 0;
        foreach (live[i])
          if (live[i].ver <= int'(rdVersion) && live[i].ver > m_ver) begin
            m_hit = 1; m_ver = live[i].ver; m_data = live[i].d;
          end
      end
      if (m_flush) begin
        live.delete(); nv = 1; m_flush = 0; m_ready = 1;
      end else begin
        if (wrValid && m_ready) begin
          if (live.size() == N) begin
            int k;
            k = 0;
`ifdef VSC_PIN_EN
            if (pinValid)
              for (int i = N - 1; i >= 0; i--) if (live[i].ver != int'(pinVersion)) k = i;
`endif
            live.delete(k);
          end
          live.push_back('{nv, wrData});
          if (nv == 2**VW - 1) m_flush = 1;
          nv++;
        end
        m_ready = !m_flush;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("wrReady", wrReady, m_ready);
    chk("rdReady", rdReady, m_ready);
    chk("validCount", validCount, live.size());
    chk("respValid", respValid, m_rv);
    if (m_ready) chk("wrVersion", wrVersion, nv);
    if (m_rv) begin
      chk("respHit", respHit, m_hit);
      chk("respData", respData, m_data);
      chk("respVersion", respVersion, m_ver);
    end
  end

  task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rv, input logic [VW-1:0] rver);
    @(negedge clk);
    wrValid = wv; wrData = wd; rdValid = rv; rdVersion = rver;
    #1;
  endtask

  task automatic idle();
    drive(0, '0, 0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst wrReady", wrReady, 0);
    chk("rst rdReady", rdReady, 0);
    chk("rst respValid", respValid, 0);
    chk("rst respHit", respHit, 0);
    chk("rst respData", respData, 0);
    chk("rst respVersion", respVersion, 0);
    chk("rst validCount", validCount, 0);
    @(negedge clk); rstN = 1;
    idle();
    chk("ready after rst", wrReady, 1);
    // read before any write misses
    drive(0, '0, 1, 4'd5); idle();
    chk("empty respValid", respValid, 1);
    chk("empty respHit", respHit, 0);
    chk("empty respData", respData, 0);
    chk("empty respVersion", respVersion, 0);
    // three writes
    drive(1, 32'hA, 0, '0); chk("wrVersion A", wrVersion, 1);
    drive(1, 32'hB, 0, '0); chk("wrVersion B", wrVersion, 2);
    drive(1, 32'hC, 0, '0); chk("wrVersion C", wrVersion, 3);
    idle();
    chk("count 3", validCount, 3);
    chk("wrReady held", wrReady, 1);
    drive(0, '0, 1, 4'd2); idle();
    chk("rd2 hit", respHit, 1);
    chk("rd2 ver", respVersion, 2);
    chk("rd2 data", respData, 32'hB);
    drive(0, '0, 1, 4'd0); idle();
    chk("rd0 hit", respHit, 0);
    chk("rd0 ver", respVersion, 0);
    chk("rd0 data", respData, 0);
    // eviction of tag 1
    drive(1, 32'hD, 0, '0);
    drive(1, 32'hE, 0, '0);
    idle();
    chk("count sat", validCount, 4);
    drive(0, '0, 1, 4'd1); idle();
    chk("evicted miss", respHit, 0);
    drive(0, '0, 1, 4'd15); idle();
    chk("rd15 ver", respVersion, 5);
    chk("rd15 data", respData, 32'hE);
    // read-before-write in the same cycle
    drive(1, 32'hF, 1, 4'd15); chk("wrVersion F", wrVersion, 6);
    idle();
    chk("rbw ver", respVersion, 5);
    chk("rbw data", respData, 32'hE);
    // run up to the version wrap
    for (int v = 7; v <= 14; v++) drive(1, 32'h100 + v, 0, '0);
    drive(1, 32'h6666, 0, '0); chk("wrVersion 15", wrVersion, 15);
    drive(0, '0, 1, 4'd15);
    chk("flush wrReady", wrReady, 0);
    chk("flush rdReady", rdReady, 0);
    idle();
    chk("flush read dropped", respValid, 0);
    chk("post flush ready", wrReady, 1);
    chk("post flush count", validCount, 0);
    drive(1, 32'h7777, 0, '0); chk("wrVersion restart", wrVersion, 1);
    drive(0, '0, 1, 4'd15); idle();
    chk("post flush ver", respVersion, 1);
    chk("post flush data", respData, 32'h7777);
    // reset with a response pending
    drive(0, '0, 1, 4'd1);
    @(posedge clk); #2;
    chk("pending resp", respValid, 1);
    rstN = 0; #1;
    chk("mid rst respValid", respValid, 0);
    chk("mid rst count", validCount, 0);
    @(negedge clk); rstN = 1;
    idle();
`ifdef VSC_PIN_EN
    for (int i = 1; i <= 4; i++) drive(1, 32'hA0 + i, 0, '0);
    pinValid = 1; pinVersion = 4'd1;
    for (int i = 5; i <= 9; i++) drive(1, 32'hA0 + i, 0, '0);
    idle();
    drive(0, '0, 1, 4'd1); idle();
    chk("pin hit", respHit, 1);
    chk("pin data", respData, 32'hA1);
    drive(0, '0, 1, 4'd2); idle();
    chk("pin evict 2", respHit, 0);
    drive(0, '0, 1, 4'd15); idle();
    chk("pin newest", respVersion, 9);
`endif
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
